// File: rtl/sequence_generator_io.sv
// Serial pattern generator: loads a frame, shifts it out MSB-first, optionally repeats with one-cycle gaps.
// Define SEQGEN_REPEAT_EN to honour repeat_ (port is "repeat_" because "repeat" is a SystemVerilog keyword).
module sequence_generator_io #(
    parameter int PAT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [PAT_W-1:0] pattern,
    input  logic [3:0]       length,
    input  logic [3:0]       repeat_,
    output logic             o,
    output logic             o_valid,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(PAT_W) + 1;
    localparam int IW = $clog2(PAT_W);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

    state_t           state;
    logic [PAT_W-1:0] pat_q;
    logic [CW-1:0]    len_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    eff_len;
    logic [CW-1:0]    nxt_cnt;
    logic [PAT_W-1:0] src;
    logic [IW-1:0]    bit_idx;
    logic             nxt_bit;

`ifdef SEQGEN_REPEAT_EN
    logic [3:0] rep_q;
`else
    logic unused_repeat;
    assign unused_repeat = ^repeat_;
`endif

    assign load_ready = (state == IDLE);
    assign busy       = (state != IDLE);

    always_comb begin
        eff_len = CW'(PAT_W);
        if (length != 4'd0 && 32'(length) <= PAT_W)
            eff_len = CW'(length);
    end

    // cnt_q holds the index of the bit currently on o; nxt_cnt is only
    // consumed when it cannot underflow.
    always_comb begin
        nxt_cnt = cnt_q - CW'(1);
        src     = pat_q;
        case (state)
            IDLE: begin
                nxt_cnt = eff_len - CW'(1);
                src     = pattern;
            end
            GAP:     nxt_cnt = len_q - CW'(1);
            default: nxt_cnt = cnt_q - CW'(1);
        endcase
        bit_idx = IW'(nxt_cnt);
        nxt_bit = src[bit_idx];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            o       <= 1'b0;
            o_valid <= 1'b0;
            done    <= 1'b0;
`ifdef SEQGEN_REPEAT_EN
            rep_q   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (load_valid) begin
                        pat_q   <= pattern;
                        len_q   <= eff_len;
                        cnt_q   <= nxt_cnt;
                        o       <= nxt_bit;
                        o_valid <= 1'b1;
                        state   <= SHIFT;
`ifdef SEQGEN_REPEAT_EN
                        rep_q   <= repeat_;
`endif
                    end
                end
                SHIFT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= nxt_cnt;
                        o     <= nxt_bit;
                    end else begin
                        o       <= 1'b0;
                        o_valid <= 1'b0;
`ifdef SEQGEN_REPEAT_EN
                        if (rep_q != 4'd0) begin
                            rep_q <= rep_q - 4'd1;
                            state <= GAP;
                        end else
`endif
                        begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    cnt_q   <= nxt_cnt;
                    o       <= nxt_bit;
                    o_valid <= 1'b1;
                    state   <= SHIFT;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
